// File: rtl/rc5_sched_pkg.sv
// Shared types and defaults for the RC5 core scheduler.
// Timer width is derived from the abort limit.
package rc5_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    RESP
  } state_t;

  localparam int CORE_LAT_D = 11;
  localparam int TIMEOUT_D  = 16;

  function automatic int tmr_w(input int t);
    return $clog2(t) + 1;
  endfunction

  localparam int TMR_W = tmr_w(TIMEOUT_D);

endpackage

// File: rtl/rc5_rr_arb2.sv
// Two-way round-robin grant; last = 1 means
// requester 1 was served last, so 0 wins a tie.
module rc5_rr_arb2 (
  input  logic v0,
  input  logic v1,
  input  logic last,
  output logic g0,
  output logic g1
);

  assign g0 = v0 & (~v1 | last);
  assign g1 = v1 & (~v0 | ~last);

endmodule

// File: rtl/rc5_core_sched.sv
// Shares one RC5 datapath core between two requesters:
// round-robin accept, launch, wait with abort, respond.
module rc5_core_sched
  import rc5_sched_pkg::*;
#(
  parameter int CORE_LAT = CORE_LAT_D,
  parameter int TIMEOUT  = TIMEOUT_D
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic        i_req0_flag,
  input  logic [63:0] i_req0_din,
  output logic        o_rsp0_valid,
  input  logic        i_rsp0_ready,
  output logic [63:0] o_rsp0_dout,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic        i_req1_flag,
  input  logic [63:0] i_req1_din,
  output logic        o_rsp1_valid,
  input  logic        i_rsp1_ready,
  output logic [63:0] o_rsp1_dout,
  output logic        o_core_flag,
  output logic [63:0] o_core_din,
  output logic        o_core_din_en,
  input  logic [63:0] i_core_dout,
  input  logic        i_core_dout_en,
  input  logic        i_err_clr,
  output logic        o_busy,
  output logic        o_timeout
);

  localparam int TW = tmr_w(TIMEOUT);

  if (TIMEOUT <= CORE_LAT) begin : g_bad_cfg
    $error("TIMEOUT must exceed CORE_LAT");
  end

  state_t        state_q;
  state_t        state_d;
  logic          last_q;
  logic          owner_q;
  logic          flag_q;
  logic          tout_q;
  logic [63:0]   din_q;
  logic [63:0]   res_q;
  logic [TW-1:0] tmr_q;

  logic g0;
  logic g1;
  logic acc;
  logic done;
  logic tmo_hit;
  logic rsp_hs;

  rc5_rr_arb2 u_arb (
    .v0   (i_req0_valid),
    .v1   (i_req1_valid),
    .last (last_q),
    .g0   (g0),
    .g1   (g1)
  );

  assign acc  = (state_q == IDLE) && (g0 | g1);
  assign done = (state_q == RUN) && i_core_dout_en;
  // a result in the final timer cycle still wins
  assign tmo_hit = (state_q == RUN) && !i_core_dout_en
                && (tmr_q == TW'(TIMEOUT - 1));
  assign rsp_hs = (state_q == RESP)
               && (owner_q ? i_rsp1_ready : i_rsp0_ready);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (g0 | g1) state_d = LAUNCH;
      LAUNCH:  state_d = RUN;
      RUN: begin
        if (done)         state_d = RESP;
        else if (tmo_hit) state_d = IDLE;
      end
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_req0_ready  = 1'b0;
    o_req1_ready  = 1'b0;
    o_core_din_en = 1'b0;
    o_rsp0_valid  = 1'b0;
    o_rsp1_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_req0_ready = g0;
        o_req1_ready = g1;
      end
      LAUNCH: o_core_din_en = 1'b1;
      RESP: begin
        o_rsp0_valid = ~owner_q;
        o_rsp1_valid = owner_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      flag_q  <= 1'b0;
      din_q   <= '0;
      res_q   <= '0;
      tmr_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      if (acc) begin
        owner_q <= g1;
        flag_q  <= g1 ? i_req1_flag : i_req0_flag;
        din_q   <= g1 ? i_req1_din : i_req0_din;
      end
      if (state_q == LAUNCH)   tmr_q <= '0;
      else if (state_q == RUN) tmr_q <= tmr_q + TW'(1);
      if (done)   res_q  <= i_core_dout;
      if (rsp_hs) last_q <= owner_q;
      if (tmo_hit)        tout_q <= 1'b1;
      else if (i_err_clr) tout_q <= 1'b0;
    end
  end

  assign o_core_flag = flag_q;
  assign o_core_din  = din_q;
  assign o_rsp0_dout = res_q;
  assign o_rsp1_dout = res_q;
  assign o_busy      = (state_q != IDLE);
  assign o_timeout   = tout_q;

endmodule

// File: tb/tb_rc5_core_sched.sv
// Directed bench for rc5_core_sched with a fixed-latency
// core model: din ^ key, key chosen by the held flag.
module tb_rc5_core_sched;
  import rc5_sched_pkg::*;

  localparam logic [63:0] KE = 64'hDF8EFB8843553DE2;
  localparam logic [63:0] KD = 64'h5A5A5A5A5A5A5A5A;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req0_valid = 1'b0;
  logic        o_req0_ready;
  logic        i_req0_flag = 1'b0;
  logic [63:0] i_req0_din = '0;
  logic        o_rsp0_valid;
  logic        i_rsp0_ready = 1'b1;
  logic [63:0] o_rsp0_dout;
  logic        i_req1_valid = 1'b0;
  logic        o_req1_ready;
  logic        i_req1_flag = 1'b0;
  logic [63:0] i_req1_din = '0;
  logic        o_rsp1_valid;
  logic        i_rsp1_ready = 1'b1;
  logic [63:0] o_rsp1_dout;
  logic        o_core_flag;
  logic [63:0] o_core_din;
  logic        o_core_din_en;
  logic [63:0] i_core_dout;
  logic        i_core_dout_en;
  logic        i_err_clr = 1'b0;
  logic        o_busy;
  logic        o_timeout;

  always #5 i_clk = ~i_clk;

  rc5_core_sched dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_req0_valid   (i_req0_valid),
    .o_req0_ready   (o_req0_ready),
    .i_req0_flag    (i_req0_flag),
    .i_req0_din     (i_req0_din),
    .o_rsp0_valid   (o_rsp0_valid),
    .i_rsp0_ready   (i_rsp0_ready),
    .o_rsp0_dout    (o_rsp0_dout),
    .i_req1_valid   (i_req1_valid),
    .o_req1_ready   (o_req1_ready),
    .i_req1_flag    (i_req1_flag),
    .i_req1_din     (i_req1_din),
    .o_rsp1_valid   (o_rsp1_valid),
    .i_rsp1_ready   (i_rsp1_ready),
    .o_rsp1_dout    (o_rsp1_dout),
    .o_core_flag    (o_core_flag),
    .o_core_din     (o_core_din),
    .o_core_din_en  (o_core_din_en),
    .i_core_dout    (i_core_dout),
    .i_core_dout_en (i_core_dout_en),
    .i_err_clr      (i_err_clr),
    .o_busy         (o_busy),
    .o_timeout      (o_timeout)
  );

  logic [3:0]  m_cnt  = '0;
  logic [63:0] m_din  = '0;
  logic        m_flag = 1'b0;
  logic        m_on   = 1'b1;

  always @(posedge i_clk) begin
    if (o_core_din_en) begin
      m_cnt  <= 4'(CORE_LAT_D);
      m_din  <= o_core_din;
      m_flag <= o_core_flag;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 4'd1;
    end
  end

  assign i_core_dout_en = m_on && (m_cnt == 4'd1);
  assign i_core_dout    = m_din ^ (m_flag ? KE : KD);

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    settle();
  endtask

  task automatic wait_rsp(input bit id,
                          output logic [63:0] d,
                          output int n);
    n = 0;
    while (!(id ? o_rsp1_valid : o_rsp0_valid) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40)
      chk("rsp_wait", id ? o_rsp1_valid : o_rsp0_valid, 1);
    d = id ? o_rsp1_dout : o_rsp0_dout;
  endtask

  logic [63:0] got;
  logic [63:0] ed;
  logic [63:0] d0;
  logic [63:0] d1;
  logic        f0;
  logic        f1;
  logic        g;
  int          n;
  int          bad;
  int          r1;

  initial begin
    // reset state
    do_reset();
    chk("rst_busy", o_busy, 0);
    chk("rst_tout", o_timeout, 0);
    chk("rst_din_en", o_core_din_en, 0);
    chk("rst_rsp", {o_rsp1_valid, o_rsp0_valid}, 0);
    chk("rst_core", {o_core_flag, o_core_din}, 0);

    // single request, cycle-exact latency
    i_req0_valid = 1'b1;
    i_req0_flag  = 1'b1;
    i_req0_din   = 64'h0123456789ABCDEF;
    settle();
    chk("s_ready", {o_req1_ready, o_req0_ready}, 2'b01);
    tick();
    i_req0_valid = 1'b0;
    settle();
    chk("s_launch", o_core_din_en, 1);
    chk("s_core_din", o_core_din, 64'h0123456789ABCDEF);
    chk("s_core_flag", o_core_flag, 1);
    bad = 0;
    r1  = 0;
    for (int c = 2; c <= 12; c++) begin
      tick();
      if (o_core_din_en || o_rsp0_valid || o_req0_ready) bad++;
      if (o_rsp1_valid) r1++;
    end
    chk("s_quiet", bad, 0);
    tick();
    chk("s_rsp_valid", o_rsp0_valid, 1);
    chk("s_rsp_dout", o_rsp0_dout, 64'hDEADBEEFCAFEF00D);
    if (o_rsp1_valid) r1++;
    tick();
    chk("s_idle", o_busy, 0);
    chk("s_no_rsp1", r1, 0);

    // contention: alternate grants, each result to its owner
    do_reset();
    d0 = 64'h1111000000000000;
    f0 = 1'b1;
    d1 = 64'h2222000000000000;
    f1 = 1'b0;
    i_req0_din   = d0;
    i_req0_flag  = f0;
    i_req1_din   = d1;
    i_req1_flag  = f1;
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b1;
    settle();
    for (int k = 0; k < 8; k++) begin
      chk("c_grant", {o_req1_ready, o_req0_ready},
          k[0] ? 2'b10 : 2'b01);
      g  = o_req1_ready;
      ed = g ? d1 ^ (f1 ? KE : KD) : d0 ^ (f0 ? KE : KD);
      tick();
      if (g) begin
        d1 = d1 + 64'd1;
        f1 = ~f1;
        i_req1_din  = d1;
        i_req1_flag = f1;
      end else begin
        d0 = d0 + 64'd1;
        f0 = ~f0;
        i_req0_din  = d0;
        i_req0_flag = f0;
      end
      wait_rsp(g, got, n);
      chk("c_data", got, ed);
      chk("c_other", g ? o_rsp0_valid : o_rsp1_valid, 0);
      tick();
    end
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;

    // flag held through a decrypt with encrypt pending
    do_reset();
    i_req1_valid = 1'b1;
    i_req1_flag  = 1'b0;
    i_req1_din   = 64'h0F0E0D0C0B0A0908;
    settle();
    chk("f_ready1", o_req1_ready, 1);
    tick();
    i_req1_valid = 1'b0;
    i_req0_valid = 1'b1;
    i_req0_flag  = 1'b1;
    i_req0_din   = 64'hAAAA5555AAAA5555;
    settle();
    bad = 0;
    n   = 0;
    while (!o_rsp1_valid && n < 40) begin
      if (o_core_flag || o_req0_ready) bad++;
      tick();
      n++;
    end
    if (o_core_flag) bad++;
    chk("f_rsp1", o_rsp1_dout, 64'h0F0E0D0C0B0A0908 ^ KD);
    chk("f_hold", bad, 0);
    tick();
    chk("f_ready0", o_req0_ready, 1);

    // response backpressure on requester 0
    i_rsp0_ready = 1'b0;
    i_req1_valid = 1'b1;
    i_req1_flag  = 1'b1;
    i_req1_din   = 64'h1357924680ACEBDF;
    tick();
    i_req0_valid = 1'b0;
    chk("b_flag", o_core_flag, 1);
    wait_rsp(1'b0, got, n);
    chk("b_lat", n, 12);
    chk("b_dout", got, 64'hAAAA5555AAAA5555 ^ KE);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!o_rsp0_valid || o_rsp0_dout !== got) bad++;
      if (o_req1_ready) bad++;
      tick();
    end
    chk("b_held", bad, 0);
    i_rsp0_ready = 1'b1;
    settle();
    chk("b_hs_ready1", o_req1_ready, 0);
    tick();
    chk("b_next_ready1", o_req1_ready, 1);
    tick();
    i_req1_valid = 1'b0;
    wait_rsp(1'b1, got, n);
    chk("b_rsp1", got, 64'h1357924680ACEBDF ^ KE);
    tick();

    // timeout: core never answers
    do_reset();
    m_on = 1'b0;
    i_req0_valid = 1'b1;
    i_req0_flag  = 1'b0;
    i_req0_din   = 64'h00000000000000FF;
    settle();
    chk("t_ready", o_req0_ready, 1);
    tick();
    i_req0_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (o_timeout || o_rsp0_valid || o_rsp1_valid) bad++;
    end
    chk("t_early", bad, 0);
    chk("t_busy16", o_busy, 1);
    tick();
    chk("t_flag", o_timeout, 1);
    chk("t_idle", o_busy, 0);
    chk("t_no_rsp", {o_rsp1_valid, o_rsp0_valid}, 0);
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    settle();
    chk("t_clear", o_timeout, 0);
    m_on = 1'b1;

    // reset in RUN, late result ignored
    do_reset();
    i_req0_valid = 1'b1;
    i_req0_flag  = 1'b0;
    i_req0_din   = 64'h7777666655554444;
    settle();
    chk("r_ready", o_req0_ready, 1);
    tick();
    i_req0_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    settle();
    chk("r_outs", {o_busy, o_timeout, o_core_din_en,
                   o_rsp0_valid, o_rsp1_valid, o_core_flag,
                   o_req0_ready, o_req1_ready}, 0);
    chk("r_core_din", o_core_din, 0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_rsp0_valid || o_rsp1_valid || o_busy) bad++;
    end
    chk("r_silent", bad, 0);
    i_req0_valid = 1'b1;
    i_req0_flag  = 1'b1;
    i_req0_din   = 64'h0123456789ABCDEF;
    settle();
    chk("r2_ready", o_req0_ready, 1);
    tick();
    i_req0_valid = 1'b0;
    wait_rsp(1'b0, got, n);
    chk("r2_lat", n, 12);
    chk("r2_dout", got, 64'hDEADBEEFCAFEF00D);
    tick();
    chk("r2_idle", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got stuck want finish");
    $fatal(1);
  end

endmodule

// File: doc/rc5_core_sched.md
Name: rc5_core_sched

Overview:
Scheduler that shares one RC5 encrypt/decrypt datapath core between two independent requesters. Each requester offers a 64-bit block plus an encrypt/decrypt flag over a valid/ready handshake. The scheduler grants requesters round-robin, launches one block at a time into the core and holds the core flag stable for the whole operation. It captures the core result, returns it to the owning requester over a valid/ready response channel, and flags a core that never completes.

Parameters:
CORE_LAT, 11, cycles from the core launch-pulse cycle to the expected i_core_dout_en cycle (informational; used only by the bench).
TIMEOUT, 16, cycles after launch without i_core_dout_en before the operation is aborted; must be > CORE_LAT.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_req0_valid  in  1  requester 0 has a block
o_req0_ready  out  1  block accepted this cycle
i_req0_flag  in  1  1 = encrypt, 0 = decrypt
i_req0_din  in  64  plaintext/ciphertext block
o_rsp0_valid  out  1  result for requester 0 available
i_rsp0_ready  in  1  requester 0 takes result
o_rsp0_dout  out  64  result block
i_req1_valid, o_req1_ready, i_req1_flag, i_req1_din, o_rsp1_valid, i_rsp1_ready, o_rsp1_dout: as above, for requester 1
o_core_flag  out  1  held mode to the core
o_core_din  out  64  block to the core
o_core_din_en  out  1  one-cycle launch pulse
i_core_dout  in  64  core result
i_core_dout_en  in  1  core result valid (single cycle)
i_err_clr  in  1  clears o_timeout
o_busy  out  1  state != IDLE
o_timeout  out  1  sticky abort flag

Behaviour:
- Clock is i_clk; reset is i_rst, synchronous, active-high; it overrides all other inputs.
- Reset values: all outputs 0; state IDLE; round-robin pointer = "last served 1", so requester 0 wins first; timer 0; result and owner registers 0.
- FSM states:
  - IDLE:
    - A request is pending if any i_reqN_valid is high. On a pending request, the arbiter picks the winner, o_reqN_ready = 1 for that one only, same cycle (combinational from valid and state).
    - On the handshake, register din, flag and owner, then go to LAUNCH.
    - Ready is never high outside IDLE.
  - LAUNCH:
    - o_core_din_en = 1 for exactly one cycle, with o_core_din and o_core_flag taken from registers.
    - Clear the timer, then go to RUN.
  - RUN:
    - The timer increments every cycle.
    - If i_core_dout_en = 1: capture i_core_dout into the result register, go to RESP.
    - Else if timer == TIMEOUT-1: set o_timeout, discard the request (no response), go to IDLE.
    - If both conditions hold in the same cycle, dout_en wins.
  - RESP:
    - o_rspN_valid = 1 for the owner only, with o_rspN_dout = the result register.
    - Valid is held until i_rspN_ready. On the handshake, go to IDLE and set the pointer to the owner.
- o_core_flag holds the registered flag from LAUNCH through RESP; it changes only when a new request is accepted. o_core_din is likewise held.
- Nominal latency: accept at cycle T, launch at T+1, core done at T+1+CORE_LAT, o_rsp valid at T+2+CORE_LAT (cycle 13 after accept with defaults).
- Arbitration: if only one requester is valid, it wins. If both are valid, the one not last served wins. The pointer updates only on response completion (timed-out requests do not update it).
- i_core_dout_en in IDLE, LAUNCH or RESP is ignored.
- i_err_clr clears o_timeout. A simultaneous set takes priority over the clear.
- Back-to-back: a request valid during RESP-completion is accepted in the following IDLE cycle (one idle bubble minimum).
- Reset mid-operation aborts silently: no response, no timeout flag.

Decomposition:
- Package rc5_sched_pkg holds:
  - state enum {IDLE, LAUNCH, RUN, RESP}
  - default CORE_LAT and TIMEOUT constants
  - timer width localparam: $clog2(TIMEOUT)+1
- Sub-module rc5_rr_arb2: two-way round-robin grant from two valids plus a last-served bit. Purely combinational grant; the pointer register stays in the parent.

Test Plan:
- Single request: req0 valid, flag = 1, din = 64'h0123456789ABCDEF; core model returns 64'hDEADBEEFCAFEF00D at 11 cycles. Expect:
  - ready0 in cycle 0
  - din_en only in cycle 1
  - rsp0_valid in cycle 13 with that value
  - rsp1_valid never asserted
- Contention: req0 and req1 both valid continuously, 4 blocks each. Expect grants in the order 0,1,0,1,... and each response routed to its owner with its own flag.
- Flag stability: req1 decrypt (flag = 0) and a req0 encrypt pending during it. Expect o_core_flag = 0 for every cycle from launch to rsp1 handshake.
- Response backpressure: hold i_rsp0_ready = 0 for 20 cycles after rsp0_valid. Expect:
  - valid and dout held stable
  - req1 not accepted until the handshake plus 1 cycle
- Timeout: the core model never asserts dout_en. Expect o_timeout = 1 exactly at the 16th RUN cycle, no response, and return to IDLE. i_err_clr = 1 then clears it.
- Reset in RUN: assert i_rst at cycle 5 after launch, then a late dout_en from the model. Expect all outputs 0, no response, and the next req0 handled normally.
